// File: rtl/tea_pkg.sv
// Shared constants and driver state encoding for the TEA register-mapped core and its stream driver.
package tea_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_KEY1   = 3'd1;
  localparam logic [2:0] ADDR_KEY2   = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;

  localparam logic [1:0] CTRL_NONE = 2'd0;
  localparam logic [1:0] CTRL_ENC  = 2'd1;
  localparam logic [1:0] CTRL_DEC  = 2'd2;

  // TEA round constant; the driver never needs it, reference models do.
  localparam logic [31:0] DELTA = 32'h9E37_79B9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_KEY0,
    ST_WR_KEY1,
    ST_WR_DATA,
    ST_WR_CTRL,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RD_ADDR,
    ST_RD_CAPT,
    ST_OUT
  } drv_state_t;

endpackage

// File: rtl/tea_stream_driver.sv
// Stream front-end for the TEA core: feeds blocks and dirty keys in, collects results out.
// Optional CBC chaining is enabled by defining TEA_STREAM_DRIVER_CBC_EN.
module tea_stream_driver
  import tea_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int BUSY_WAIT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
`ifdef TEA_STREAM_DRIVER_CBC_EN
  input  logic [WORD_SIZE-1:0]   i_iv,
  input  logic                   i_iv_load,
`endif
  input  logic [2*WORD_SIZE-1:0] i_key,
  input  logic                   i_key_load,
  input  logic                   i_mode,
  input  logic [WORD_SIZE-1:0]   i_in_data,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  output logic [WORD_SIZE-1:0]   o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_busy,
  output logic [WORD_SIZE-1:0]   o_tea_data,
  output logic [2:0]             o_tea_addr,
  output logic                   o_tea_we,
  input  logic [WORD_SIZE-1:0]   i_tea_data,
  input  logic                   i_tea_ready
);

  localparam int CNT_W = $clog2(BUSY_WAIT + 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_WAIT - 1);

  drv_state_t               state, state_next;
  logic [2*WORD_SIZE-1:0]   key_reg;
  logic                     key_dirty;
  logic [WORD_SIZE-1:0]     block;
  logic                     mode;
  logic [CNT_W-1:0]         busy_cnt;
  logic                     accept;
  logic [WORD_SIZE-1:0]     data_word;
  logic [WORD_SIZE-1:0]     result_out;
  logic [WORD_SIZE-1:0]     tea_data;
  logic [2:0]               tea_addr;
  logic                     tea_we;

  assign o_in_ready = (state == ST_IDLE) && !o_out_valid && !i_rst;
  assign accept     = i_in_valid && o_in_ready;
  assign o_busy     = (state != ST_IDLE);
  assign o_tea_data = tea_data;
  assign o_tea_addr = tea_addr;
  assign o_tea_we   = tea_we;

`ifdef TEA_STREAM_DRIVER_CBC_EN
  logic [WORD_SIZE-1:0] chain;

  // Encrypt chains on the ciphertext it produced, decrypt on the ciphertext it consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      chain <= '0;
    end else if (i_iv_load) begin
      chain <= i_iv;
    end else if (state == ST_RD_CAPT) begin
      chain <= mode ? block : i_tea_data;
    end
  end

  assign data_word  = mode ? block : (block ^ chain);
  assign result_out = mode ? (i_tea_data ^ chain) : i_tea_data;
`else
  assign data_word  = block;
  assign result_out = i_tea_data;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      key_reg     <= '0;
      key_dirty   <= 1'b0;
      block       <= '0;
      mode        <= 1'b0;
      busy_cnt    <= '0;
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
    end else begin
      state <= state_next;

      // A load landing during WR_KEY1 may have split the halves, so it keeps the key dirty.
      if (i_key_load) begin
        key_reg   <= i_key;
        key_dirty <= 1'b1;
      end else if (state == ST_WR_KEY1) begin
        key_dirty <= 1'b0;
      end

      if (accept) begin
        block <= i_in_data;
        mode  <= i_mode;
      end

      if (state == ST_WAIT_BUSY) begin
        if (busy_cnt != BUSY_LAST) busy_cnt <= busy_cnt + 1'b1;
      end else begin
        busy_cnt <= '0;
      end

      if (state == ST_RD_CAPT) begin
        o_out_data  <= result_out;
        o_out_valid <= 1'b1;
      end else if (state == ST_OUT && i_out_ready) begin
        o_out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    tea_addr   = ADDR_DATA;
    tea_we     = 1'b0;
    tea_data   = '0;
    case (state)
      ST_IDLE: begin
        // A key load in the acceptance cycle applies to this block.
        if (accept) state_next = (key_dirty || i_key_load) ? ST_WR_KEY0 : ST_WR_DATA;
      end
      ST_WR_KEY0: begin
        tea_addr   = ADDR_KEY1;
        tea_we     = 1'b1;
        tea_data   = key_reg[WORD_SIZE-1:0];
        state_next = ST_WR_KEY1;
      end
      ST_WR_KEY1: begin
        tea_addr   = ADDR_KEY2;
        tea_we     = 1'b1;
        tea_data   = key_reg[2*WORD_SIZE-1:WORD_SIZE];
        state_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        tea_addr   = ADDR_DATA;
        tea_we     = 1'b1;
        tea_data   = data_word;
        state_next = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        tea_addr   = ADDR_CTRL;
        tea_we     = 1'b1;
        tea_data   = {{(WORD_SIZE-2){1'b0}}, (mode ? CTRL_DEC : CTRL_ENC)};
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A core fast enough to never show busy is caught by the timeout.
        tea_addr = ADDR_RESULT;
        if (!i_tea_ready || busy_cnt == BUSY_LAST) state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tea_addr = ADDR_RESULT;
        if (i_tea_ready) state_next = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        tea_addr   = ADDR_RESULT;
        state_next = ST_RD_CAPT;
      end
      ST_RD_CAPT: begin
        tea_addr   = ADDR_RESULT;
        state_next = ST_OUT;
      end
      ST_OUT: begin
        if (i_out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tea_stream_driver.sv
// Self-checking bench for tea_stream_driver with a behavioural TEA core and reference model.
// Define TEA_STREAM_DRIVER_CBC_EN to also exercise the CBC chaining ports.
module tb_tea_stream_driver;
  import tea_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = '0;
  logic         key_load = 1'b0;
  logic         mode = 1'b0;
  logic [63:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic [63:0]  tea_wdata;
  logic [2:0]   tea_addr;
  logic         tea_we;
  logic [63:0]  tea_rdata = '0;
  logic         core_ready = 1'b1;
`ifdef TEA_STREAM_DRIVER_CBC_EN
  logic [63:0]  iv = '0;
  logic         iv_load = 1'b0;
`endif

  always #5 clk = ~clk;

  tea_stream_driver #(.WORD_SIZE(64), .BUSY_WAIT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
`ifdef TEA_STREAM_DRIVER_CBC_EN
    .i_iv        (iv),
    .i_iv_load   (iv_load),
`endif
    .i_key       (key),
    .i_key_load  (key_load),
    .i_mode      (mode),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_tea_data  (tea_wdata),
    .o_tea_addr  (tea_addr),
    .o_tea_we    (tea_we),
    .i_tea_data  (tea_rdata),
    .i_tea_ready (core_ready)
  );

  // TEA in plain arithmetic; key words k0..k3 are 32-bit slices from the low end.
  function automatic logic [63:0] tea_enc(input logic [63:0] blk, input logic [127:0] k);
    logic [31:0] v0, v1, s;
    v0 = blk[31:0];
    v1 = blk[63:32];
    s  = '0;
    for (int r = 0; r < 32; r++) begin
      s  = s + DELTA;
      v0 = v0 + (((v1 << 4) + k[31:0]) ^ (v1 + s) ^ ((v1 >> 5) + k[63:32]));
      v1 = v1 + (((v0 << 4) + k[95:64]) ^ (v0 + s) ^ ((v0 >> 5) + k[127:96]));
    end
    return {v1, v0};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] blk, input logic [127:0] k);
    logic [31:0] v0, v1, s;
    v0 = blk[31:0];
    v1 = blk[63:32];
    s  = DELTA * 32;
    for (int r = 0; r < 32; r++) begin
      v1 = v1 - (((v0 << 4) + k[95:64]) ^ (v0 + s) ^ ((v0 >> 5) + k[127:96]));
      v0 = v0 - (((v1 << 4) + k[31:0]) ^ (v1 + s) ^ ((v1 >> 5) + k[63:32]));
      s  = s - DELTA;
    end
    return {v1, v0};
  endfunction

  // Behavioural core: register file, run time set by the bench, registered read port.
  logic [63:0] core_data = '0, core_klo = '0, core_khi = '0;
  logic [63:0] core_result = '0, core_pend = '0, core_val;
  int          core_cnt = 0;
  int          core_run_len = 0;

  always @(posedge clk) begin
    if (tea_we) begin
      case (tea_addr)
        ADDR_DATA: core_data <= tea_wdata;
        ADDR_KEY1: core_klo  <= tea_wdata;
        ADDR_KEY2: core_khi  <= tea_wdata;
        ADDR_CTRL: begin
          if (tea_wdata[1:0] == CTRL_ENC || tea_wdata[1:0] == CTRL_DEC) begin
            core_val = (tea_wdata[1:0] == CTRL_DEC) ? tea_dec(core_data, {core_khi, core_klo})
                                                    : tea_enc(core_data, {core_khi, core_klo});
            if (core_run_len == 0) begin
              core_result <= core_val;
              core_ready  <= 1'b1;
              core_cnt    <= 0;
            end else begin
              core_pend  <= core_val;
              core_ready <= 1'b0;
              core_cnt   <= core_run_len;
            end
          end
        end
        default: ;
      endcase
    end else if (!core_ready) begin
      if (core_cnt <= 1) begin
        core_ready  <= 1'b1;
        core_result <= core_pend;
      end
      core_cnt <= core_cnt - 1;
    end
    if (!tea_we && tea_addr == ADDR_RESULT) tea_rdata <= core_result;
  end

  // Bus monitor: key writes per block, first write after acceptance, write-bus hygiene.
  int cyc = 0, acc_cyc = 0, key_writes = 0, first_gap = 0, viol = 0;
  logic [2:0] first_addr = '0;
  bit first_pend = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!tea_we && tea_wdata != '0) viol++;
    if (tea_we && tea_addr > ADDR_CTRL) viol++;
    if (tea_we && (tea_addr == ADDR_KEY1 || tea_addr == ADDR_KEY2)) key_writes++;
    if (first_pend && tea_we) begin
      first_addr = tea_addr;
      first_gap  = cyc - acc_cyc;
      first_pend = 1'b0;
    end
    if (in_valid && in_ready) begin
      acc_cyc    = cyc;
      first_pend = 1'b1;
      key_writes = 0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: key and chain as the stream user sees them, not as the core does.
  logic [127:0] m_key = '0;
  logic [63:0]  m_chain = '0;

  function automatic logic [63:0] model_step(input logic [63:0] d, input logic m);
`ifdef TEA_STREAM_DRIVER_CBC_EN
    logic [63:0] r;
    if (!m) begin
      r = tea_enc(d ^ m_chain, m_key);
      m_chain = r;
    end else begin
      r = tea_dec(d, m_key) ^ m_chain;
      m_chain = d;
    end
    return r;
`else
    return m ? tea_dec(d, m_key) : tea_enc(d, m_key);
`endif
  endfunction

  task automatic applyStimulus(input logic [63:0] d, input logic m, input logic do_load,
                               input logic [127:0] k);
    bit acc;
    int n;
    in_data  = d;
    mode     = m;
    key      = k;
    key_load = do_load;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      acc = in_ready;
      tick();
      key_load = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    checkOutput("accept", acc, 1);
  endtask

  task automatic collect(input int stall, output logic [63:0] data);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    checkOutput("out_valid_seen", out_valid, 1);
    repeat (stall) tick();
    data = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("valid_dropped", out_valid, 0);
  endtask

  typedef struct {
    logic         load;
    logic [127:0] key;
    logic         mode;
    logic [63:0]  data;
    int           run_len;
    int           exp_kw;
    logic [2:0]   exp_first;
    logic [63:0]  exp;
    logic         use_model;
  } vec_t;

  vec_t        tbl[6];
  logic [63:0] exp, got, d, snap, c1, c2;
  logic [127:0] k;
  logic        m, ld, hold_ok;

  initial begin
    tbl[0] = '{1'b1, 128'h0, 1'b0, 64'h0, 5, 2, ADDR_KEY1, 64'h94BAA940_41EA3A0A, 1'b0};
    tbl[1] = '{1'b0, 128'h0, 1'b1, 64'h94BAA940_41EA3A0A, 0, 0, ADDR_DATA, 64'h0, 1'b0};
    tbl[2] = '{1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 64'h01234567_89ABCDEF,
               3, 2, ADDR_KEY1, 64'h0, 1'b1};
    tbl[3] = '{1'b0, 128'h0, 1'b1, 64'hDEADBEEF_CAFEF00D, 12, 0, ADDR_DATA, 64'h0, 1'b1};
    tbl[4] = '{1'b0, 128'h0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1, 0, ADDR_DATA, 64'h0, 1'b1};
    tbl[5] = '{1'b1, {128{1'b1}}, 1'b1, 64'h0, 2, 2, ADDR_KEY1, 64'h0, 1'b1};
`ifdef TEA_STREAM_DRIVER_CBC_EN
    tbl[1].use_model = 1'b1;
`endif

    // Reset state while reset is held.
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out", {out_valid, out_data}, 65'h0);
    checkOutput("rst_tea_bus", {tea_we, tea_addr, tea_wdata}, 68'h0);
    rst = 1'b0;
    tick();
    checkOutput("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      core_run_len = tbl[i].run_len;
      if (tbl[i].load) m_key = tbl[i].key;
      exp = model_step(tbl[i].data, tbl[i].mode);
      if (!tbl[i].use_model) exp = tbl[i].exp;
      applyStimulus(tbl[i].data, tbl[i].mode, tbl[i].load, tbl[i].key);
      collect(i % 3, got);
      checkOutput($sformatf("tbl%0d_data", i), got, exp);
      checkOutput($sformatf("tbl%0d_key_writes", i), key_writes, tbl[i].exp_kw);
      checkOutput($sformatf("tbl%0d_first_addr", i), first_addr, tbl[i].exp_first);
      checkOutput($sformatf("tbl%0d_first_gap", i), first_gap, 1);
    end

    // Output backpressure: 20 stalled cycles with data held and input closed.
    core_run_len = 3;
    d = 64'h13579BDF_2468ACE0;
    exp = model_step(d, 1'b0);
    applyStimulus(d, 1'b0, 1'b0, '0);
    for (int n = 0; n < 300 && !out_valid; n++) tick();
    snap = out_data;
    hold_ok = out_valid;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (!out_valid || out_data !== snap || in_ready) hold_ok = 1'b0;
    end
    checkOutput("stall_hold", hold_ok, 1);
    checkOutput("stall_data", snap, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("stall_release", {out_valid, busy, in_ready}, 3'b001);

    // Key load while a block is in flight: old key for it, new key for the next.
    core_run_len = 8;
    d = 64'hA5A5A5A5_5A5A5A5A;
    exp = model_step(d, 1'b0);
    applyStimulus(d, 1'b0, 1'b0, '0);
    tick();
    tick();
    key = 128'h01234567_89ABCDEF_FEDCBA98_7654CDEF;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    m_key = key;
    collect(0, got);
    checkOutput("midload_old_key", got, exp);
    checkOutput("midload_no_kw", key_writes, 0);
    core_run_len = 2;
    d = 64'h0BADF00D_0C0FFEE0;
    exp = model_step(d, 1'b0);
    applyStimulus(d, 1'b0, 1'b0, '0);
    collect(1, got);
    checkOutput("midload_new_key", got, exp);
    checkOutput("midload_kw", key_writes, 2);

    // Reset during WAIT_DONE, then a fresh block with a reloaded key.
    core_run_len = 40;
    applyStimulus(64'h11112222_33334444, 1'b0, 1'b0, '0);
    repeat (4) tick();
    checkOutput("pre_rst_busy", {busy, out_valid}, 2'b10);
    rst = 1'b1;
    tick();
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_out", {out_valid, out_data}, 65'h0);
    checkOutput("midrst_tea_bus", {tea_we, tea_addr, tea_wdata}, 68'h0);
    rst = 1'b0;
    tick();
    checkOutput("postrst_in_ready", in_ready, 1);
    m_chain = '0;
    core_run_len = 4;
    k = 128'hCAFEBABE_DEADBEEF_00000001_80000000;
    m_key = k;
    d = 64'h55555555_AAAAAAAA;
    exp = model_step(d, 1'b0);
    applyStimulus(d, 1'b0, 1'b1, k);
    collect(0, got);
    checkOutput("postrst_data", got, exp);
    checkOutput("postrst_kw", key_writes, 2);

    // Random traffic against the reference model.
    for (int i = 0; i < 20; i++) begin
      ld = ($urandom_range(0, 3) == 0);
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      core_run_len = $urandom_range(0, 10);
      if (ld) m_key = k;
      exp = model_step(d, m);
      applyStimulus(d, m, ld, k);
      collect($urandom_range(0, 3), got);
      checkOutput($sformatf("rand%0d_data", i), got, exp);
      checkOutput($sformatf("rand%0d_kw", i), key_writes, ld ? 2 : 0);
    end

`ifdef TEA_STREAM_DRIVER_CBC_EN
    // CBC round trip from a loaded IV.
    iv = 64'h0F0F0F0F_0F0F0F0F;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    m_chain = iv;
    core_run_len = 3;
    exp = model_step(64'h00000000_00000001, 1'b0);
    applyStimulus(64'h00000000_00000001, 1'b0, 1'b0, '0);
    collect(0, c1);
    checkOutput("cbc_enc1", c1, exp);
    exp = model_step(64'h00000000_00000001, 1'b0);
    applyStimulus(64'h00000000_00000001, 1'b0, 1'b0, '0);
    collect(0, c2);
    checkOutput("cbc_enc2", c2, exp);
    checkOutput("cbc_chain_differs", (c1 != c2), 1);
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    m_chain = iv;
    exp = model_step(c1, 1'b1);
    applyStimulus(c1, 1'b1, 1'b0, '0);
    collect(0, got);
    checkOutput("cbc_dec1", got, 64'h00000000_00000001);
    checkOutput("cbc_dec1_model", got, exp);
    exp = model_step(c2, 1'b1);
    applyStimulus(c2, 1'b1, 1'b0, '0);
    collect(0, got);
    checkOutput("cbc_dec2", got, 64'h00000000_00000001);
    checkOutput("cbc_dec2_model", got, exp);
`endif

    checkOutput("write_bus_rules", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
